// File: rtl/video_timing_gen_pkg.sv
// Mode constants and helpers shared by the video timing generator and its users.
package video_timing_pkg;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        int pclk_khz;
    } video_mode_t;

    localparam video_mode_t MODE_640x480_60 = '{640, 16, 96, 48, 480, 10, 2, 33, 25000};
    localparam video_mode_t MODE_800x600_72 = '{800, 56, 120, 64, 600, 37, 6, 23, 50000};

    function automatic int axis_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to hold the value v (at least one).
    function automatic int min_width(int v);
        return (v <= 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel-enable in, timing/position out; master is the timing generator.
interface video_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10,
    parameter int FW = 8
);
    logic          pix_en;
    logic [XW-1:0] xpos;
    logic [YW-1:0] ypos;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          line_start;
    logic          frame_start;
    logic          vblank_start;
    logic [FW-1:0] frame_count;

    modport master (
        input  pix_en,
        output xpos, ypos, hsync, vsync, de,
        output line_start, frame_start, vblank_start, frame_count
    );

    modport slave (
        output pix_en,
        input  xpos, ypos, hsync, vsync, de,
        input  line_start, frame_start, vblank_start, frame_count
    );
endinterface

// File: rtl/video_timing_gen_axis_counter.sv
// One timing axis: position counter plus registered active/sync flags decoded
// from the next count, so the flags always describe the count they sit beside.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = SYNC_ACTIVE_LOW,
    parameter int W      = 10
) (
    input  logic         clk25,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);
    localparam int          TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_lengths
        $error("video_axis_counter: every active/porch/sync length must be >= 1");
    end
    if (min_width(TOTAL - 1) > W) begin : g_bad_width
        $error("video_axis_counter: W too narrow for TOTAL-1");
    end

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;
    logic         active_reg;
    logic         sync_reg;

    assign wrap       = adv && (count_reg == LAST);
    assign count_next = wrap ? '0 : count_reg + W'(1);

    // Reset parks on the last back-porch position so the first advance lands on 0.
    always_ff @(posedge clk25) begin
        if (reset) begin
            count_reg  <= LAST;
            active_reg <= 1'b0;
            sync_reg   <= ~POL;
        end else if (adv) begin
            count_reg  <= count_next;
            active_reg <= (count_next < ACTIVE_END);
            sync_reg   <= (count_next >= SYNC_FIRST && count_next <= SYNC_LAST) ? POL : ~POL;
        end
    end

    assign count  = count_reg;
    assign active = active_reg;
    assign sync   = sync_reg;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised VGA-style timing generator: counters, syncs, display enable,
// line/frame/vblank strobes and a frame counter, all aligned to xpos/ypos.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = SYNC_ACTIVE_LOW,
    parameter bit V_POL    = SYNC_ACTIVE_LOW,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int FW       = 8
) (
    input  logic                clk25,
    input  logic                reset,
    video_timing_gen_if.master  vt
);
    localparam logic [YW-1:0] V_LAST_ACTIVE = YW'(V_ACTIVE - 1);

    if (FW < 1) begin : g_bad_fw
        $error("video_timing_gen: FW must be >= 1");
    end

    logic [XW-1:0] h_count;
    logic [YW-1:0] v_count;
    logic          h_wrap, v_wrap;
    logic          h_active, v_active;
    logic          h_sync, v_sync;

    video_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .W(XW)
    ) u_h (
        .clk25(clk25), .reset(reset), .adv(vt.pix_en),
        .count(h_count), .wrap(h_wrap), .active(h_active), .sync(h_sync)
    );

    // The vertical axis steps only on the horizontal wrap, so vsync moves with ypos.
    video_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .W(YW)
    ) u_v (
        .clk25(clk25), .reset(reset), .adv(h_wrap),
        .count(v_count), .wrap(v_wrap), .active(v_active), .sync(v_sync)
    );

    logic          line_start_reg;
    logic          frame_start_reg;
    logic          vblank_start_reg;
    logic [FW-1:0] frame_count_reg;

    // Strobes decode the position being entered; h_wrap means the next xpos is 0.
    always_ff @(posedge clk25) begin
        if (reset) begin
            line_start_reg   <= 1'b0;
            frame_start_reg  <= 1'b0;
            vblank_start_reg <= 1'b0;
            frame_count_reg  <= '1;
        end else if (vt.pix_en) begin
            line_start_reg   <= h_wrap;
            frame_start_reg  <= v_wrap;
            vblank_start_reg <= h_wrap && (v_count == V_LAST_ACTIVE);
            if (v_wrap) begin
                frame_count_reg <= frame_count_reg + FW'(1);
            end
        end
    end

    assign vt.xpos         = h_count;
    assign vt.ypos         = v_count;
    assign vt.hsync        = h_sync;
    assign vt.vsync        = v_sync;
    assign vt.de           = h_active & v_active;
    assign vt.line_start   = line_start_reg;
    assign vt.frame_start  = frame_start_reg;
    assign vt.vblank_start = vblank_start_reg;
    assign vt.frame_count  = frame_count_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Three generators (640x480 default, 800x600 active-high, tiny mode with FW=2)
// checked every cycle against a linear-pixel-index reference model.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    typedef struct {
        int ha, hf, hsw, hb;
        int va, vf, vsw, vb;
        bit hp, vp;
        int fw;
    } tb_mode_t;

    logic clk25 = 1'b0;
    logic reset = 1'b1;
    always #20 clk25 = ~clk25;

    video_timing_gen_if #(.XW(10), .YW(10), .FW(8)) vt0 ();
    video_timing_gen_if #(.XW(11), .YW(10), .FW(8)) vt1 ();
    video_timing_gen_if #(.XW(4),  .YW(4),  .FW(2)) vt2 ();

    video_timing_gen dut0 (.clk25(clk25), .reset(reset), .vt(vt0));

    video_timing_gen #(
        .H_ACTIVE(MODE_800x600_72.h_active), .H_FP(MODE_800x600_72.h_fp),
        .H_SYNC(MODE_800x600_72.h_sync), .H_BP(MODE_800x600_72.h_bp),
        .V_ACTIVE(MODE_800x600_72.v_active), .V_FP(MODE_800x600_72.v_fp),
        .V_SYNC(MODE_800x600_72.v_sync), .V_BP(MODE_800x600_72.v_bp),
        .H_POL(SYNC_ACTIVE_HIGH), .V_POL(SYNC_ACTIVE_HIGH), .XW(11), .YW(10), .FW(8)
    ) dut1 (.clk25(clk25), .reset(reset), .vt(vt1));

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(SYNC_ACTIVE_LOW), .V_POL(SYNC_ACTIVE_HIGH), .XW(4), .YW(4), .FW(2)
    ) dut2 (.clk25(clk25), .reset(reset), .vt(vt2));

    logic [63:0] obs0, obs1, obs2;
    assign obs0 = {16'(vt0.xpos), 16'(vt0.ypos), 16'(vt0.frame_count), 10'd0, vt0.hsync,
                   vt0.vsync, vt0.de, vt0.line_start, vt0.frame_start, vt0.vblank_start};
    assign obs1 = {16'(vt1.xpos), 16'(vt1.ypos), 16'(vt1.frame_count), 10'd0, vt1.hsync,
                   vt1.vsync, vt1.de, vt1.line_start, vt1.frame_start, vt1.vblank_start};
    assign obs2 = {16'(vt2.xpos), 16'(vt2.ypos), 16'(vt2.frame_count), 10'd0, vt2.hsync,
                   vt2.vsync, vt2.de, vt2.line_start, vt2.frame_start, vt2.vblank_start};

    tb_mode_t md [3];
    int       p  [3];   // linear pixel index within the frame
    int       fc [3];
    int       vectors = 0;
    int       miscompares = 0;
    int       cyc = 0;

    function automatic int htot(int d);
        return md[d].ha + md[d].hf + md[d].hsw + md[d].hb;
    endfunction

    function automatic int vtot(int d);
        return md[d].va + md[d].vf + md[d].vsw + md[d].vb;
    endfunction

    function automatic logic [63:0] obs(int d);
        case (d)
            0:       return obs0;
            1:       return obs1;
            default: return obs2;
        endcase
    endfunction

    function automatic logic [63:0] exp_pack(int d);
        int x, y;
        bit hs, vs, de, ls, fs, vb;
        x  = p[d] % htot(d);
        y  = p[d] / htot(d);
        hs = (x >= md[d].ha + md[d].hf && x < md[d].ha + md[d].hf + md[d].hsw) ? md[d].hp : !md[d].hp;
        vs = (y >= md[d].va + md[d].vf && y < md[d].va + md[d].vf + md[d].vsw) ? md[d].vp : !md[d].vp;
        de = (x < md[d].ha) && (y < md[d].va);
        ls = (x == 0);
        fs = ls && (y == 0);
        vb = ls && (y == md[d].va);
        return {16'(x), 16'(y), 16'(fc[d]), 10'd0, hs, vs, de, ls, fs, vb};
    endfunction

    // Drive one clock with the given reset/enables and advance the model.
    task automatic tick(input bit rst, input bit [2:0] en);
        reset      = rst;
        vt0.pix_en = en[0];
        vt1.pix_en = en[1];
        vt2.pix_en = en[2];
        @(posedge clk25);
        #1;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                p[d]  = htot(d) * vtot(d) - 1;
                fc[d] = (1 << md[d].fw) - 1;
            end else if (en[d]) begin
                p[d] = (p[d] + 1) % (htot(d) * vtot(d));
                if (p[d] == 0) fc[d] = (fc[d] + 1) % (1 << md[d].fw);
            end
        end
    endtask

    task automatic test_reset();
        tick(1'b1, 3'b111);
        tick(1'b1, 3'b000);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (obs(d) !== exp_pack(d)) begin
                miscompares++;
                $display("FAIL reset_model dut%0d got=%h expected=%h", d, obs(d), exp_pack(d));
            end
        end
        vectors++;
        if ({vt0.xpos, vt0.ypos, vt0.de, vt0.hsync, vt0.vsync, vt0.line_start, vt0.frame_start,
             vt0.vblank_start, vt0.frame_count} !== {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 3'b000, 8'hFF}) begin
            miscompares++;
            $display("FAIL reset_state dut0 got x=%0d y=%0d de=%b hs=%b vs=%b fc=%0d expected 799/524/0/1/1/255",
                     vt0.xpos, vt0.ypos, vt0.de, vt0.hsync, vt0.vsync, vt0.frame_count);
        end
        vectors++;
        if ({vt1.xpos, vt1.ypos, vt1.hsync, vt1.vsync} !== {11'd1039, 10'd665, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state dut1 got x=%0d y=%0d hs=%b vs=%b expected 1039/665/0/0",
                     vt1.xpos, vt1.ypos, vt1.hsync, vt1.vsync);
        end
        $display("reset: checked reset state of all generators at cycle %0d", cyc);
    endtask

    task automatic test_first_cycle();
        tick(1'b0, 3'b111);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (obs(d) !== exp_pack(d)) begin
                miscompares++;
                $display("FAIL first_cycle_model dut%0d got=%h expected=%h", d, obs(d), exp_pack(d));
            end
        end
        vectors++;
        if ({vt0.xpos, vt0.ypos, vt0.de, vt0.frame_start, vt0.line_start, vt0.frame_count, vt0.hsync, vt0.vsync}
            !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL first_cycle dut0 got x=%0d y=%0d de=%b fs=%b ls=%b fc=%0d expected 0/0/1/1/1/0",
                     vt0.xpos, vt0.ypos, vt0.de, vt0.frame_start, vt0.line_start, vt0.frame_count);
        end
        $display("first_cycle: (x,y)=(%0d,%0d) frame_start=%b", vt0.xpos, vt0.ypos, vt0.frame_start);
    endtask

    task automatic test_one_line();
        int low0 = 0, first0 = -1, last0 = -1, ls0 = 0;
        int high1 = 0, first1 = -1, last1 = -1;
        for (int i = 0; i < 1040; i++) begin
            tick(1'b0, 3'b111);
            for (int d = 0; d < 3; d++) begin
                vectors++;
                if (obs(d) !== exp_pack(d)) begin
                    miscompares++;
                    $display("FAIL line_model dut%0d cyc=%0d got=%h expected=%h", d, cyc, obs(d), exp_pack(d));
                end
            end
            if (vt0.hsync === 1'b0) begin
                low0++;
                if (first0 < 0) first0 = int'(vt0.xpos);
                last0 = int'(vt0.xpos);
            end
            if (vt0.line_start === 1'b1) ls0++;
            if (vt1.hsync === 1'b1) begin
                high1++;
                if (first1 < 0) first1 = int'(vt1.xpos);
                last1 = int'(vt1.xpos);
            end
        end
        vectors++;
        if (low0 != 96 || first0 != 656 || last0 != 751 || ls0 != 1) begin
            miscompares++;
            $display("FAIL hsync_window dut0 got len=%0d span=%0d..%0d ls=%0d expected 96 656..751 1",
                     low0, first0, last0, ls0);
        end
        vectors++;
        if (high1 != 120 || first1 != 856 || last1 != 975) begin
            miscompares++;
            $display("FAIL hsync_window dut1 got len=%0d span=%0d..%0d expected 120 856..975",
                     high1, first1, last1);
        end
        $display("one_line: dut0 hsync low %0d cycles, dut1 hsync high %0d cycles", low0, high1);
    endtask

    task automatic test_toggle();
        int  rises[$];
        int  run = 0, first_run = -1;
        bit  prev = vt0.line_start;
        for (int i = 0; i < 3400; i++) begin
            tick(1'b0, (i % 2 == 0) ? 3'b111 : 3'b000);
            for (int d = 0; d < 3; d++) begin
                vectors++;
                if (obs(d) !== exp_pack(d)) begin
                    miscompares++;
                    $display("FAIL toggle_model dut%0d cyc=%0d got=%h expected=%h", d, cyc, obs(d), exp_pack(d));
                end
            end
            if (vt0.line_start === 1'b1) begin
                if (!prev) rises.push_back(cyc);
                run++;
            end else if (prev) begin
                if (first_run < 0) first_run = run;
                run = 0;
            end
            prev = vt0.line_start;
        end
        vectors++;
        if (rises.size() < 2 || rises[1] - rises[0] != 1600 || first_run != 2) begin
            miscompares++;
            $display("FAIL toggle_period dut0 got rises=%0d period=%0d width=%0d expected period 1600 width 2",
                     rises.size(), (rises.size() >= 2) ? rises[1] - rises[0] : -1, first_run);
        end
        $display("toggle: line_start rises=%0d strobe width=%0d", rises.size(), first_run);
    endtask

    task automatic test_frames();
        int fcs[$];
        int fs_cyc[$];
        int vb_cnt = 0;
        tick(1'b1, 3'b111);
        for (int i = 0; i < 5 * 135 + 1; i++) begin
            tick(1'b0, 3'b111);
            for (int d = 0; d < 3; d++) begin
                vectors++;
                if (obs(d) !== exp_pack(d)) begin
                    miscompares++;
                    $display("FAIL frames_model dut%0d cyc=%0d got=%h expected=%h", d, cyc, obs(d), exp_pack(d));
                end
            end
            if (vt2.frame_start === 1'b1) begin
                fcs.push_back(int'(vt2.frame_count));
                fs_cyc.push_back(cyc);
            end
            if (vt2.vblank_start === 1'b1) begin
                vb_cnt++;
                vectors++;
                if (vt2.xpos !== 4'd0 || vt2.ypos !== 4'd5) begin
                    miscompares++;
                    $display("FAIL vblank_pos dut2 got (%0d,%0d) expected (0,5)", vt2.xpos, vt2.ypos);
                end
            end
        end
        vectors++;
        if (fcs.size() < 5 || fcs[0] != 0 || fcs[1] != 1 || fcs[2] != 2 || fcs[3] != 3 || fcs[4] != 0
            || fs_cyc[1] - fs_cyc[0] != 135 || vb_cnt != 5) begin
            miscompares++;
            $display("FAIL frame_seq dut2 got n=%0d fc0..4=%0d,%0d,%0d,%0d,%0d vb=%0d expected 0,1,2,3,0 period 135 vb 5",
                     fcs.size(), (fcs.size() > 0) ? fcs[0] : -1, (fcs.size() > 1) ? fcs[1] : -1,
                     (fcs.size() > 2) ? fcs[2] : -1, (fcs.size() > 3) ? fcs[3] : -1,
                     (fcs.size() > 4) ? fcs[4] : -1, vb_cnt);
        end
        $display("frames: dut2 saw %0d frame starts, %0d vblank starts", fcs.size(), vb_cnt);
    endtask

    task automatic test_random();
        int rst_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            rst = ($urandom_range(0, 199) == 0);
            if (rst) rst_cnt++;
            tick(rst, 3'($urandom));
            for (int d = 0; d < 3; d++) begin
                vectors++;
                if (obs(d) !== exp_pack(d)) begin
                    miscompares++;
                    $display("FAIL random_model dut%0d cyc=%0d got=%h expected=%h", d, cyc, obs(d), exp_pack(d));
                end
            end
        end
        $display("random: 3000 cycles with %0d resets", rst_cnt);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 300; i++) tick(1'b0, 3'b111);
        tick(1'b1, 3'b111);
        vectors++;
        if ({vt0.xpos, vt0.ypos, vt0.de, vt0.frame_start} !== {10'd799, 10'd524, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset dut0 got x=%0d y=%0d de=%b fs=%b expected 799/524/0/0",
                     vt0.xpos, vt0.ypos, vt0.de, vt0.frame_start);
        end
        tick(1'b0, 3'b000);
        vectors++;
        if (obs0 !== exp_pack(0)) begin
            miscompares++;
            $display("FAIL mid_reset_hold dut0 got=%h expected=%h", obs0, exp_pack(0));
        end
        tick(1'b0, 3'b111);
        vectors++;
        if ({vt0.xpos, vt0.ypos, vt0.frame_start, vt0.frame_count} !== {10'd0, 10'd0, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL mid_reset_restart dut0 got x=%0d y=%0d fs=%b fc=%0d expected 0/0/1/0",
                     vt0.xpos, vt0.ypos, vt0.frame_start, vt0.frame_count);
        end
        $display("mid_reset: restart at (%0d,%0d)", vt0.xpos, vt0.ypos);
    endtask

    initial begin
        md[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8};
        md[1] = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1, 8};
        md[2] = '{8, 2, 3, 2, 5, 1, 2, 1, 1'b0, 1'b1, 2};
        vt0.pix_en = 1'b0;
        vt1.pix_en = 1'b0;
        vt2.pix_en = 1'b0;
        test_reset();
        test_first_cycle();
        test_one_line();
        test_toggle();
        test_frames();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
